pwm_cmd_ctrl: RTL and testbench
===============================

Name: pwm_cmd_ctrl

Overview:
- Parametrised N-channel PWM LED controller driven by a byte-command stream from serial_rx.
- Reports channel state back through serial_tx.
- Successor to the fixed three-channel RGB PWM logic: adds generic channel count, duty width and prescaler, glitch-free double-buffered duty updates, and a queued readback handshake.
- Sits between the UART blocks and the LED/GPIO pins in the top level.

Parameters:
CHANNELS, 3, number of PWM outputs (1..8)
DUTY_W, 7, duty/period counter width in bits (2..8)
PRESCALE, 8, clk cycles per PWM counter step (>=1)
ACTIVE_LOW, 1, 1: pwm_out inverted (LED on = 0)
RESET_DUTY, 0, duty value loaded into every channel on reset

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
rx_data  in  8  received byte, valid when rx_valid=1
rx_valid  in  1  single-cycle strobe, one per received byte
query  in  1  readback request, level input; rising edge triggers
tx_data  out  8  byte to transmit: {mode, duty of selected channel, zero-padded to 7 bits}
tx_send  out  1  transmit request to serial_tx
tx_busy  in  1  serial_tx busy flag
pwm_out  out  CHANNELS  PWM outputs, bit i = channel i
sel_ch  out  3  currently selected channel index
mode  out  1  1 = SELECT mode, 0 = VALUE mode

Behaviour:
- Reset is synchronous and active-high. When reset=1 at a clk edge:
  - mode=1, sel_ch=0.
  - All pending and active duties = RESET_DUTY.
  - Prescaler = 0, period counter = 0.
  - tx FSM = IDLE, tx_send=0, tx_data=0, query edge register = 0.
  - pwm_out = all 1s if ACTIVE_LOW, else all 0s.
- Reset mid-transmission abandons the request immediately; tx_send=0 on the next cycle.
- Prescaler:
  - Counts 0..PRESCALE-1.
  - tick=1 for the single cycle where the count equals PRESCALE-1, then the count wraps to 0.
  - PRESCALE=1 gives tick every cycle.
- Period counter (DUTY_W bits):
  - Increments on tick and wraps 2^DUTY_W-1 -> 0.
  - wrap = tick AND counter at max.
- Output: raw_i = (period counter < active_duty_i), unsigned compare. pwm_out_i = raw_i XOR ACTIVE_LOW, registered (one-cycle latency).
  - duty=0: output permanently inactive.
  - duty=2^DUTY_W-1: active for all but one step per period.
- Double buffering:
  - Commands write pending_duty only.
  - On wrap, every active_duty_i <= pending_duty_i.
  - If a write and wrap coincide, active takes the pre-write pending value; the new value applies at the following wrap.
- Command decode, evaluated only when rx_valid=1:
  - 0x3D '=': toggle mode. No other effect.
  - 0x3F '?': queue readback, in either mode.
  - mode=1: byte 0x30+k with k<CHANNELS sets sel_ch=k. All other bytes are ignored.
  - mode=0: any other byte sets pending_duty[sel_ch] <= rx_data[DUTY_W-1:0] (upper bits dropped).
- Readback request:
  - Sources are a query rising edge (query registered once; edge = query & ~query_q) or a '?' byte.
  - Captured in a single req flag. Requests arriving while req=1 are merged (not counted).
- tx FSM:
  - IDLE: if req and !tx_busy, latch tx_data = {mode, 7-bit zero-extended pending_duty[sel_ch]}, set tx_send=1, clear req -> SEND.
  - SEND: hold tx_send=1 and tx_data stable until tx_busy=1, then tx_send=0 -> WAIT.
  - WAIT: when tx_busy=0 -> IDLE.
  - At most one byte in flight. A new req during SEND/WAIT is served after returning to IDLE.
- Simultaneous events:
  - rx_valid and query edge in the same cycle: both processed. A '?' plus an edge yields one readback.
  - A command that changes sel_ch or duty in the same cycle tx_data is latched: tx_data uses the pre-update values.

Test Plan:
- Reset with CHANNELS=3, ACTIVE_LOW=1 -> pwm_out=3'b111, mode=1, sel_ch=0, tx_send=0. Hold 3*PRESCALE*128 cycles; outputs stay 1.
- Bytes '1', '=', 0x40 (DUTY_W=7, PRESCALE=8) -> channel 1 pending=64, active unchanged until next wrap. Afterwards pwm_out[1]=0 for exactly 64*8 clk and 1 for 64*8 clk per 1024-clk period.
- Write 0x10 to ch0 on the exact wrap cycle -> the period after the wrap uses the old duty; the 0x10 duty appears one period later with no runt pulse.
- In mode=1 send '7' with CHANNELS=3 -> sel_ch unchanged. Send 0x3F -> tx_send=1, tx_data=0x80|pending[sel_ch]. Model tx_busy high 2 cycles later for 10 cycles -> tx_send drops when busy rises; FSM idles after busy falls.
- Three query edges plus a '?' byte during one WAIT -> exactly one further transmission after the current one.
- Assert reset while in SEND -> tx_send=0 next cycle, all duties = RESET_DUTY, outputs inactive.

Source files
------------

// File: rtl/pwm_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pwm_cmd_ctrl
// Description : N-channel PWM LED controller driven by a byte command stream.
//               Duty updates are double-buffered and applied at period wrap;
//               channel state is reported back through a one-byte handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_cmd_ctrl #(
    parameter int CHANNELS   = 3,
    parameter int DUTY_W     = 7,
    parameter int PRESCALE   = 8,
    parameter bit ACTIVE_LOW = 1'b1,
    parameter int RESET_DUTY = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    input  logic                query,
    output logic [7:0]          tx_data,
    output logic                tx_send,
    input  logic                tx_busy,
    output logic [CHANNELS-1:0] pwm_out,
    output logic [2:0]          sel_ch,
    output logic                mode
);

    localparam int                  c_PS_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [c_PS_W-1:0]   c_PS_MAX   = c_PS_W'(PRESCALE - 1);
    localparam logic [DUTY_W-1:0]   c_PER_MAX  = '1;
    localparam logic [DUTY_W-1:0]   c_RST_DUTY = DUTY_W'(RESET_DUTY);
    localparam logic [CHANNELS-1:0] c_PWM_OFF  = {CHANNELS{ACTIVE_LOW}};
    localparam logic [7:0]          c_CMD_MODE  = 8'h3D;
    localparam logic [7:0]          c_CMD_QUERY = 8'h3F;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_SEND = 2'd1;
    localparam logic [1:0] c_ST_WAIT = 2'd2;

    logic [c_PS_W-1:0]   r_presc;
    logic [DUTY_W-1:0]   r_period;
    logic [DUTY_W-1:0]   r_pending [CHANNELS];
    logic [DUTY_W-1:0]   r_active  [CHANNELS];
    logic [CHANNELS-1:0] r_pwm;
    logic [2:0]          r_sel;
    logic                r_mode;
    logic                r_query_q;
    logic                r_req;
    logic [1:0]          r_state;
    logic [7:0]          r_tx_data;
    logic                r_tx_send;

    logic                w_tick;
    logic                w_wrap;
    logic                w_is_mode;
    logic                w_is_query;
    logic                w_is_sel;
    logic                w_is_duty;
    logic                w_qedge;
    logic                w_launch;
    logic [CHANNELS-1:0] w_raw;
    logic [DUTY_W-1:0]   w_sel_duty;
    logic [6:0]          w_duty7;

    assign w_tick     = (r_presc == c_PS_MAX);
    assign w_wrap     = w_tick && (r_period == c_PER_MAX);
    assign w_is_mode  = rx_valid && (rx_data == c_CMD_MODE);
    assign w_is_query = rx_valid && (rx_data == c_CMD_QUERY);
    // A select byte is '0'..'7' restricted to channels that exist
    assign w_is_sel   = rx_valid && r_mode && (rx_data[7:3] == 5'b00110)
                        && ({1'b0, rx_data[2:0]} < 4'(CHANNELS));
    assign w_is_duty  = rx_valid && !r_mode && !w_is_mode && !w_is_query;
    assign w_qedge    = query & ~r_query_q;
    assign w_launch   = (r_state == c_ST_IDLE) && r_req && !tx_busy;

    // Prescaler: free-running divider producing a one-cycle tick
    always_ff @(posedge clk) begin
        if (reset)       r_presc <= '0;
        else if (w_tick) r_presc <= '0;
        else             r_presc <= r_presc + 1'b1;
    end

    // Period counter: advances on tick, wraps naturally at all-ones
    always_ff @(posedge clk) begin
        if (reset)       r_period <= '0;
        else if (w_tick) r_period <= r_period + 1'b1;
    end

    // Mode toggle and channel selection
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mode <= 1'b1;
            r_sel  <= 3'd0;
        end else begin
            if (w_is_mode) r_mode <= ~r_mode;
            if (w_is_sel)  r_sel  <= rx_data[2:0];
        end
    end

    // Duty buffers: commands hit pending; active copies pending only at wrap,
    // so a write on the wrap cycle lands one full period later
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_pending[i] <= c_RST_DUTY;
                r_active[i]  <= c_RST_DUTY;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (w_wrap)
                    r_active[i] <= r_pending[i];
                if (w_is_duty && (r_sel == 3'(i)))
                    r_pending[i] <= rx_data[DUTY_W-1:0];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_raw
            assign w_raw[gi] = (r_period < r_active[gi]);
        end
    endgenerate

    // Registered PWM outputs with polarity applied
    always_ff @(posedge clk) begin
        if (reset) r_pwm <= c_PWM_OFF;
        else       r_pwm <= w_raw ^ c_PWM_OFF;
    end

    // Pending duty of the selected channel for readback
    always_comb begin
        w_sel_duty = r_pending[0];
        for (int i = 0; i < CHANNELS; i++) begin
            if (r_sel == 3'(i)) w_sel_duty = r_pending[i];
        end
    end

    generate
        if (DUTY_W >= 7) begin : g_duty_trunc
            assign w_duty7 = w_sel_duty[6:0];
        end else begin : g_duty_pad
            assign w_duty7 = {{(7 - DUTY_W){1'b0}}, w_sel_duty};
        end
    endgenerate

    // Readback request flag: edges and '?' bytes merge into one pending request;
    // a new request in the launch cycle keeps the flag set so it is not lost
    always_ff @(posedge clk) begin
        if (reset) begin
            r_query_q <= 1'b0;
            r_req     <= 1'b0;
        end else begin
            r_query_q <= query;
            if (w_qedge || w_is_query) r_req <= 1'b1;
            else if (w_launch)         r_req <= 1'b0;
        end
    end

    // Transmit handshake: one byte in flight, held until the transmitter is busy
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_ST_IDLE;
            r_tx_send <= 1'b0;
            r_tx_data <= 8'd0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_launch) begin
                        r_tx_data <= {r_mode, w_duty7};
                        r_tx_send <= 1'b1;
                        r_state   <= c_ST_SEND;
                    end
                end
                c_ST_SEND: begin
                    if (tx_busy) begin
                        r_tx_send <= 1'b0;
                        r_state   <= c_ST_WAIT;
                    end
                end
                c_ST_WAIT: begin
                    if (!tx_busy) r_state <= c_ST_IDLE;
                end
                default: begin
                    r_tx_send <= 1'b0;
                    r_state   <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign tx_data = r_tx_data;
    assign tx_send = r_tx_send;
    assign pwm_out = r_pwm;
    assign sel_ch  = r_sel;
    assign mode    = r_mode;

endmodule
`default_nettype wire

// File: tb/tb_pwm_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwm_cmd_ctrl
// Description : Directed self-checking bench for pwm_cmd_ctrl (3 channels,
//               7-bit duty, prescale 8, active-low outputs).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_cmd_ctrl;

    localparam int CHANNELS   = 3;
    localparam int DUTY_W     = 7;
    localparam int PRESCALE   = 8;
    localparam bit ACTIVE_LOW = 1'b1;
    localparam int RESET_DUTY = 0;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] rx_data = 8'd0;
    logic       rx_valid = 1'b0;
    logic       query = 1'b0;
    logic [7:0] tx_data;
    logic       tx_send;
    logic       tx_busy = 1'b0;
    logic [2:0] pwm_out;
    logic [2:0] sel_ch;
    logic       mode;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    logic [2:0] hist [0:16383];

    pwm_cmd_ctrl #(
        .CHANNELS   (CHANNELS),
        .DUTY_W     (DUTY_W),
        .PRESCALE   (PRESCALE),
        .ACTIVE_LOW (ACTIVE_LOW),
        .RESET_DUTY (RESET_DUTY)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .query    (query),
        .tx_data  (tx_data),
        .tx_send  (tx_send),
        .tx_busy  (tx_busy),
        .pwm_out  (pwm_out),
        .sel_ch   (sel_ch),
        .mode     (mode)
    );

    always #5 clk = ~clk;

    // Clock edges since reset release: during the low phase with cyc==n,
    // outputs reflect edge n-1 and inputs driven now are sampled at edge n
    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // PWM output history indexed by cycle
    always @(negedge clk) begin
        if (!reset) hist[cyc] = pwm_out;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic at_neg(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic send_byte(input int n, input logic [7:0] b);
        at_neg(n);
        rx_data  = b;
        rx_valid = 1'b1;
        at_neg(n + 1);
        rx_valid = 1'b0;
    endtask

    function automatic int count_low(input int lo, input int hi, input int b);
        int z = 0;
        for (int c = lo; c <= hi; c++) if (hist[c][b] == 1'b0) z++;
        return z;
    endfunction

    function automatic int count_not_off(input int lo, input int hi);
        int z = 0;
        for (int c = lo; c <= hi; c++) if (hist[c] != 3'b111) z++;
        return z;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
        $fatal(1, "timeout");
    end

    initial begin
        int sends;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_pwm", 32'(pwm_out), 32'h7);
        chk("rst_mode", 32'(mode), 32'h1);
        chk("rst_sel", 32'(sel_ch), 32'h0);
        chk("rst_send", 32'(tx_send), 32'h0);
        chk("rst_data", 32'(tx_data), 32'h00);
        reset = 1'b0;

        // Zero duty keeps all outputs off for three full periods
        at_neg(3073);
        chk("hold_off", 32'(count_not_off(1, 3072)), 32'd0);

        // Select channel 1, VALUE mode, duty 64
        send_byte(3080, 8'h31);
        send_byte(3082, 8'h3D);
        send_byte(3084, 8'h40);
        at_neg(3085);
        chk("b_mode", 32'(mode), 32'h0);
        chk("b_sel", 32'(sel_ch), 32'h1);
        at_neg(5122);
        chk("b_before_wrap", 32'(count_low(3085, 4096, 1)), 32'd0);
        chk("b_4096", 32'(hist[4096][1]), 32'h1);
        chk("b_4097", 32'(hist[4097][1]), 32'h0);
        chk("b_4608", 32'(hist[4608][1]), 32'h0);
        chk("b_4609", 32'(hist[4609][1]), 32'h1);
        chk("b_5121", 32'(hist[5121][1]), 32'h0);
        chk("b_on_count", 32'(count_low(4097, 5120, 1)), 32'd512);
        chk("b_ch0_off", 32'(count_low(4097, 5120, 0)), 32'd0);
        chk("b_ch2_off", 32'(count_low(4097, 5120, 2)), 32'd0);

        // Channel 0: duty 8, then 0x10 written exactly on the wrap edge 6143
        send_byte(5200, 8'h3D);
        send_byte(5202, 8'h30);
        send_byte(5204, 8'h3D);
        send_byte(5206, 8'h08);
        send_byte(6143, 8'h10);
        at_neg(8193);
        chk("c_before", 32'(count_low(5122, 6144, 0)), 32'd0);
        chk("c_6145", 32'(hist[6145][0]), 32'h0);
        chk("c_6208", 32'(hist[6208][0]), 32'h0);
        chk("c_6209", 32'(hist[6209][0]), 32'h1);
        chk("c_old_count", 32'(count_low(6145, 7168, 0)), 32'd64);
        chk("c_7169", 32'(hist[7169][0]), 32'h0);
        chk("c_7296", 32'(hist[7296][0]), 32'h0);
        chk("c_7297", 32'(hist[7297][0]), 32'h1);
        chk("c_new_count", 32'(count_low(7169, 8192, 0)), 32'd128);

        // SELECT mode: out-of-range select ignored, then readback of ch1
        send_byte(8300, 8'h3D);
        send_byte(8302, 8'h37);
        at_neg(8303);
        chk("d_mode", 32'(mode), 32'h1);
        chk("d_sel_ignored", 32'(sel_ch), 32'h0);
        send_byte(8304, 8'h31);
        send_byte(8306, 8'h3F);
        at_neg(8307);
        chk("d_send_pre", 32'(tx_send), 32'h0);
        at_neg(8308);
        chk("d_send", 32'(tx_send), 32'h1);
        chk("d_data", 32'(tx_data), 32'hC0);
        at_neg(8310);
        tx_busy = 1'b1;
        chk("d_hold_send", 32'(tx_send), 32'h1);
        chk("d_hold_data", 32'(tx_data), 32'hC0);
        at_neg(8311);
        chk("d_send_drop", 32'(tx_send), 32'h0);
        // Three query edges, a '?' byte and a mode toggle while in WAIT
        at_neg(8312); query = 1'b1;
        at_neg(8313); query = 1'b0;
        at_neg(8314); query = 1'b1;
        at_neg(8315); query = 1'b0;
        at_neg(8316); query = 1'b1;
        at_neg(8317); query = 1'b0;
        send_byte(8318, 8'h3F);
        send_byte(8319, 8'h3D);
        at_neg(8320);
        tx_busy = 1'b0;
        chk("d_wait_nosend", 32'(tx_send), 32'h0);
        at_neg(8321);
        chk("d_idle_nosend", 32'(tx_send), 32'h0);
        at_neg(8322);
        chk("d_send2", 32'(tx_send), 32'h1);
        chk("d_data2", 32'(tx_data), 32'h40);
        at_neg(8324);
        tx_busy = 1'b1;
        at_neg(8328);
        tx_busy = 1'b0;
        sends = 0;
        for (int c = 8325; c <= 8340; c++) begin
            at_neg(c);
            if (tx_send) sends++;
        end
        chk("d_single_extra", 32'(sends), 32'd0);

        // Reset while in SEND
        send_byte(8400, 8'h3F);
        at_neg(8402);
        chk("e_send", 32'(tx_send), 32'h1);
        chk("e_pwm_pre", 32'(pwm_out), 32'h5);
        reset = 1'b1;
        @(negedge clk);
        chk("e_send_abort", 32'(tx_send), 32'h0);
        chk("e_pwm_off", 32'(pwm_out), 32'h7);
        chk("e_mode", 32'(mode), 32'h1);
        chk("e_sel", 32'(sel_ch), 32'h0);
        chk("e_data", 32'(tx_data), 32'h00);
        @(negedge clk);
        reset = 1'b0;
        send_byte(10, 8'h31);
        send_byte(12, 8'h3F);
        at_neg(14);
        chk("e_rb_send", 32'(tx_send), 32'h1);
        chk("e_rb_data", 32'(tx_data), 32'h80);
        at_neg(16);
        tx_busy = 1'b1;
        at_neg(20);
        tx_busy = 1'b0;
        at_neg(1101);
        chk("e_hold_off", 32'(count_not_off(1, 1100)), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
